// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
package bp_pkg;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_JMP = 2'b11;

   typedef enum logic [1:0] {SNT, WNT, WT, ST} bp_cnt_t;

   // tag is held at full width; bits above 32-(IDX_BITS+2) are always zero
   typedef struct packed {
      logic        valid;
      logic [31:0] tag;
      logic [31:0] target;
      bp_cnt_t     cnt;
   } bp_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-state function of a 2-bit saturating direction counter.
module bp_sat_counter
   import bp_pkg::*;
(
   input  bp_cnt_t cnt,
   input  logic    taken,
   output bp_cnt_t cnt_next
);

   always_comb begin
      cnt_next = cnt;
      if (taken) begin
         if (cnt != ST) cnt_next = bp_cnt_t'(cnt + 2'd1);
      end else begin
         if (cnt != SNT) cnt_next = bp_cnt_t'(cnt - 2'd1);
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: fetch-stage lookup, execute-stage
// mispredict detection, table training and a saturating mispredict counter.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int unsigned IDX_BITS = 4,
   parameter logic [1:0]  CNT_INIT = 2'b01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic [6:0]  ex_opcode,
   input  logic [1:0]  ex_pcsrc,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [31:0] mispredict_count
);

   localparam int unsigned ENTRIES = 2 ** IDX_BITS;
   localparam int unsigned TAG_LSB = IDX_BITS + 2;

   bp_entry_t           table_q [ENTRIES];
   bp_entry_t           lk_entry;
   bp_entry_t           up_entry;
   bp_entry_t           wr_entry;
   logic [IDX_BITS-1:0] lk_idx;
   logic [IDX_BITS-1:0] up_idx;
   logic                lk_hit;
   logic                up_hit;
   logic                actual_taken;
   logic                wr_en;
   bp_cnt_t             cnt_next;

   assign lk_idx      = if_pc[TAG_LSB-1:2];
   assign lk_entry    = table_q[lk_idx];
   assign lk_hit      = lk_entry.valid && (lk_entry.tag == (if_pc >> TAG_LSB));
   assign pred_taken  = lk_hit && lk_entry.cnt[1];
   assign pred_target = pred_taken ? lk_entry.target : if_pc + 32'd4;

   assign actual_taken = (ex_pcsrc != PCSRC_SEQ);
   assign mispredict   = ex_valid && ((actual_taken != ex_pred_taken) ||
                                      (actual_taken && (ex_pred_target != ex_target)));
   assign redirect_pc  = actual_taken ? ex_target : ex_pc + 32'd4;

   assign up_idx   = ex_pc[TAG_LSB-1:2];
   assign up_entry = table_q[up_idx];
   assign up_hit   = up_entry.valid && (up_entry.tag == (ex_pc >> TAG_LSB));

   bp_sat_counter u_sat_counter (
      .cnt      (up_entry.cnt),
      .taken    (actual_taken),
      .cnt_next (cnt_next)
   );

   always_comb begin
      wr_en    = 1'b0;
      wr_entry = up_entry;
      if (ex_valid) begin
         if (ex_opcode == OP_BRANCH) begin
            if (up_hit) begin
               wr_en        = 1'b1;
               wr_entry.cnt = cnt_next;
               if (actual_taken) wr_entry.target = ex_target;
            end else if (actual_taken) begin
               wr_en    = 1'b1;
               wr_entry = '{valid: 1'b1, tag: ex_pc >> TAG_LSB, target: ex_target, cnt: WT};
            end
         end else if (ex_opcode == OP_JAL) begin
            wr_en    = 1'b1;
            wr_entry = '{valid: 1'b1, tag: ex_pc >> TAG_LSB, target: ex_target, cnt: ST};
         end
      end
   end

   // only valid/cnt are reset; stale tag/target are masked by valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            table_q[i].valid <= 1'b0;
            table_q[i].cnt   <= bp_cnt_t'(CNT_INIT);
         end
      end else if (wr_en) begin
         table_q[up_idx] <= wr_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mispredict_count <= '0;
      end else if (mispredict && (mispredict_count != '1)) begin
         mispredict_count <= mispredict_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor against an array-based
// reference model of the BTB rules.
module tb_branch_predictor;

   localparam int IDX     = 4;
   localparam int ENTRIES = 1 << IDX;
   localparam logic [6:0] BR   = 7'b1100011;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111;
   localparam logic [6:0] ALU  = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] if_pc = '0;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid = 1'b0;
   logic [31:0] ex_pc = '0;
   logic [6:0]  ex_opcode = '0;
   logic [1:0]  ex_pcsrc = '0;
   logic [31:0] ex_target = '0;
   logic        ex_pred_taken = 1'b0;
   logic [31:0] ex_pred_target = '0;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] mispredict_count;

   int n_vec = 0;
   int n_err = 0;

   bit          m_valid [ENTRIES];
   logic [31:0] m_pc    [ENTRIES];
   logic [31:0] m_tgt   [ENTRIES];
   int          m_cnt   [ENTRIES];
   logic [31:0] m_count;

   branch_predictor #(.IDX_BITS(IDX), .CNT_INIT(2'b01)) dut (
      .clk(clk), .rst(rst), .if_pc(if_pc),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode),
      .ex_pcsrc(ex_pcsrc), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .mispredict(mispredict), .redirect_pc(redirect_pc),
      .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   function automatic int midx(input logic [31:0] pc);
      return int'((pc >> 2) & (ENTRIES - 1));
   endfunction

   function automatic bit mhit(input logic [31:0] pc);
      int i = midx(pc);
      return m_valid[i] && ((m_pc[i] >> (IDX + 2)) == (pc >> (IDX + 2)));
   endfunction

   function automatic bit mpt(input logic [31:0] pc);
      return mhit(pc) && (m_cnt[midx(pc)] >= 2);
   endfunction

   function automatic logic [31:0] mptg(input logic [31:0] pc);
      return mpt(pc) ? m_tgt[midx(pc)] : pc + 32'd4;
   endfunction

   function automatic bit mmisp();
      bit t = (ex_pcsrc != 2'b00);
      return ex_valid && ((t != ex_pred_taken) || (t && (ex_pred_target != ex_target)));
   endfunction

   function automatic logic [31:0] mredir();
      return (ex_pcsrc != 2'b00) ? ex_target : ex_pc + 32'd4;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 1'b0;
         m_cnt[i]   = 1;
      end
      m_count = '0;
   endtask

   task automatic model_update();
      int i;
      bit t;
      if (!ex_valid) return;
      i = midx(ex_pc);
      t = (ex_pcsrc != 2'b00);
      if (ex_opcode == BR) begin
         if (mhit(ex_pc)) begin
            if (t) m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
            else   m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            if (t) m_tgt[i] = ex_target;
         end else if (t) begin
            m_valid[i] = 1'b1; m_pc[i] = ex_pc; m_tgt[i] = ex_target; m_cnt[i] = 2;
         end
      end else if (ex_opcode == JAL) begin
         m_valid[i] = 1'b1; m_pc[i] = ex_pc; m_tgt[i] = ex_target; m_cnt[i] = 3;
      end
   endtask

   task automatic drive_ex(input bit v, input logic [31:0] pc, input logic [6:0] op,
                           input logic [1:0] src, input logic [31:0] tgt);
      ex_valid = v; ex_pc = pc; ex_opcode = op; ex_pcsrc = src; ex_target = tgt;
      ex_pred_taken = mpt(pc); ex_pred_target = mptg(pc);
   endtask

   task automatic tick();
      bit mp = mmisp();
      @(posedge clk); #1;
      if (mp && (m_count != 32'hFFFF_FFFF)) m_count = m_count + 32'd1;
      model_update();
   endtask

   function automatic logic [31:0] rand_pc();
      case ($urandom % 4)
         0, 1:    return 32'($urandom_range(0, 31)) << 2;
         2:       return 32'h0000_1000 + (32'($urandom_range(0, 31)) << 2);
         default: return 32'hFFFF_FFC0 + (32'($urandom_range(0, 15)) << 2);
      endcase
   endfunction

   task automatic test_reset();
      #1 rst = 1'b1;
      if_pc = 32'h100;
      #2;
      n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_pred_taken: got %b expected 0", pred_taken); end
      n_vec++; if (pred_target !== 32'h104) begin n_err++; $display("FAIL reset_pred_target: got %h expected 00000104", pred_target); end
      n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL reset_mispredict: got %b expected 0", mispredict); end
      n_vec++; if (mispredict_count !== 32'h0) begin n_err++; $display("FAIL reset_count: got %h expected 0", mispredict_count); end
      if_pc = 32'hFFFF_FFFC;
      #1;
      n_vec++; if (pred_target !== 32'h0) begin n_err++; $display("FAIL wrap_pred_target: got %h expected 00000000", pred_target); end
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      if_pc = 32'h100;
      drive_ex(1'b1, 32'h100, BR, 2'b00, 32'h180);
      #2;
      n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL seq_mispredict: got %b expected 0", mispredict); end
      tick();
      n_vec++; if (mispredict_count !== 32'h0) begin n_err++; $display("FAIL seq_count: got %h expected 0", mispredict_count); end
   endtask

   task automatic test_branch_training();
      if_pc = 32'h40;
      drive_ex(1'b1, 32'h40, BR, 2'b01, 32'h80);
      #2;
      n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL first_taken_mispredict: got %b expected 1", mispredict); end
      n_vec++; if (redirect_pc !== 32'h80) begin n_err++; $display("FAIL first_taken_redirect: got %h expected 00000080", redirect_pc); end
      tick();
      n_vec++; if (mispredict_count !== 32'h1) begin n_err++; $display("FAIL first_taken_count: got %h expected 1", mispredict_count); end
      ex_valid = 1'b0;
      #2;
      n_vec++; if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin n_err++; $display("FAIL alloc_lookup: got %b/%h expected 1/00000080", pred_taken, pred_target); end
      for (int k = 0; k < 3; k++) begin
         drive_ex(1'b1, 32'h40, BR, 2'b01, 32'h80);
         #2;
         n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL taken_again_%0d: got %b expected 0", k, mispredict); end
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         drive_ex(1'b1, 32'h40, BR, 2'b00, 32'h80);
         #2;
         n_vec++; if (mispredict !== 1'b1 || redirect_pc !== 32'h44) begin n_err++; $display("FAIL not_taken_%0d: got %b/%h expected 1/00000044", k, mispredict, redirect_pc); end
         tick();
      end
      ex_valid = 1'b0;
      #2;
      n_vec++; if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin n_err++; $display("FAIL wnt_lookup: got %b/%h expected 0/00000044", pred_taken, pred_target); end
      n_vec++; if (mispredict_count !== m_count) begin n_err++; $display("FAIL training_count: got %h expected %h", mispredict_count, m_count); end
   endtask

   task automatic test_jal_jalr();
      drive_ex(1'b1, 32'h200, JAL, 2'b11, 32'h1000);
      #2;
      n_vec++; if (mispredict !== 1'b1 || redirect_pc !== 32'h1000) begin n_err++; $display("FAIL jal_first: got %b/%h expected 1/00001000", mispredict, redirect_pc); end
      tick();
      ex_valid = 1'b0; if_pc = 32'h200;
      #2;
      n_vec++; if (pred_taken !== 1'b1 || pred_target !== 32'h1000) begin n_err++; $display("FAIL jal_lookup: got %b/%h expected 1/00001000", pred_taken, pred_target); end
      drive_ex(1'b1, 32'h200, JAL, 2'b11, 32'h1000);
      #2;
      n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL jal_second: got %b expected 0", mispredict); end
      tick();
      for (int k = 0; k < 2; k++) begin
         drive_ex(1'b1, 32'h300, JALR, 2'b11, 32'h500);
         #2;
         n_vec++; if (mispredict !== 1'b1 || redirect_pc !== 32'h500) begin n_err++; $display("FAIL jalr_%0d: got %b/%h expected 1/00000500", k, mispredict, redirect_pc); end
         tick();
      end
      ex_valid = 1'b0; if_pc = 32'h300;
      #2;
      n_vec++; if (pred_taken !== 1'b0 || pred_target !== 32'h304) begin n_err++; $display("FAIL jalr_no_alloc: got %b/%h expected 0/00000304", pred_taken, pred_target); end
      n_vec++; if (mispredict_count !== m_count) begin n_err++; $display("FAIL jump_count: got %h expected %h", mispredict_count, m_count); end
   endtask

   task automatic test_aliasing();
      drive_ex(1'b1, 32'h40, BR, 2'b01, 32'h80);
      tick();
      drive_ex(1'b1, 32'h80, BR, 2'b01, 32'h10);
      tick();
      ex_valid = 1'b0; if_pc = 32'h40;
      #1;
      n_vec++; if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin n_err++; $display("FAIL alias_evicted: got %b/%h expected 0/00000044", pred_taken, pred_target); end
      if_pc = 32'h80;
      #1;
      n_vec++; if (pred_taken !== 1'b1 || pred_target !== 32'h10) begin n_err++; $display("FAIL alias_new: got %b/%h expected 1/00000010", pred_taken, pred_target); end
   endtask

   task automatic test_same_cycle();
      if_pc = 32'h80;
      drive_ex(1'b1, 32'h80, JAL, 2'b11, 32'h900);
      #2;
      n_vec++; if (pred_taken !== 1'b1 || pred_target !== 32'h10) begin n_err++; $display("FAIL same_cycle_old: got %b/%h expected 1/00000010", pred_taken, pred_target); end
      n_vec++; if (mispredict !== 1'b1 || redirect_pc !== 32'h900) begin n_err++; $display("FAIL same_cycle_resolve: got %b/%h expected 1/00000900", mispredict, redirect_pc); end
      tick();
      ex_valid = 1'b0;
      #2;
      n_vec++; if (pred_taken !== 1'b1 || pred_target !== 32'h900) begin n_err++; $display("FAIL same_cycle_new: got %b/%h expected 1/00000900", pred_taken, pred_target); end
   endtask

   task automatic test_random(input int iters);
      logic [6:0] op;
      logic [1:0] src;
      logic [31:0] pc;
      for (int k = 0; k < iters; k++) begin
         pc = rand_pc();
         case ($urandom % 8)
            0, 1, 2, 3: begin op = BR;   src = ($urandom % 2) ? 2'b01 : 2'b00; end
            4:          begin op = JAL;  src = 2'b11; end
            5:          begin op = JALR; src = 2'b11; end
            default:    begin op = ALU;  src = 2'b00; end
         endcase
         drive_ex(($urandom % 100) < 85, pc, op, src, rand_pc());
         if (($urandom % 4) == 0) begin
            ex_pred_taken  = $urandom % 2;
            ex_pred_target = rand_pc();
         end
         if_pc = (($urandom % 3) == 0) ? pc : rand_pc();
         #2;
         n_vec++; if (pred_taken !== mpt(if_pc) || pred_target !== mptg(if_pc)) begin n_err++; $display("FAIL rand_lookup[%0d] pc=%h: got %b/%h expected %b/%h", k, if_pc, pred_taken, pred_target, mpt(if_pc), mptg(if_pc)); end
         n_vec++; if (mispredict !== mmisp()) begin n_err++; $display("FAIL rand_mispredict[%0d]: got %b expected %b", k, mispredict, mmisp()); end
         n_vec++; if (redirect_pc !== mredir()) begin n_err++; $display("FAIL rand_redirect[%0d]: got %h expected %h", k, redirect_pc, mredir()); end
         tick();
         n_vec++; if (mispredict_count !== m_count) begin n_err++; $display("FAIL rand_count[%0d]: got %h expected %h", k, mispredict_count, m_count); end
      end
   endtask

   task automatic test_mid_reset();
      drive_ex(1'b1, 32'h40, BR, 2'b01, 32'h80);
      #2 rst = 1'b1;
      #1;
      n_vec++; if (mispredict_count !== 32'h0) begin n_err++; $display("FAIL midrst_count: got %h expected 0", mispredict_count); end
      model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         if_pc = 32'(i) << 2;
         #1;
         n_vec++; if (pred_taken !== 1'b0 || pred_target !== if_pc + 32'd4) begin n_err++; $display("FAIL midrst_lookup[%0d]: got %b/%h expected 0/%h", i, pred_taken, pred_target, if_pc + 32'd4); end
      end
      @(posedge clk); #1;
      ex_valid = 1'b0;
      rst = 1'b0;
      if_pc = 32'h40;
      #1;
      n_vec++; if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin n_err++; $display("FAIL midrst_no_train: got %b/%h expected 0/00000044", pred_taken, pred_target); end
      n_vec++; if (mispredict_count !== 32'h0) begin n_err++; $display("FAIL post_rst_count: got %h expected 0", mispredict_count); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_branch_training();
      test_jal_jalr();
      test_aliasing();
      test_same_cycle();
      test_random(400);
      test_mid_reset();
      test_random(100);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
